// File: rtl/dual_regbank_mbox_if.sv
// Register-bus interface shared by the HPS and NIOS sides of dual_regbank_mbox.
// One access is a single-cycle request (bus_enable) answered by a one-cycle
// acknowledge pulse; read_data is valid while acknowledge is high.
interface dual_regbank_mbox_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] address;
   logic              bus_enable;
   logic              rw;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] read_data;
   logic              acknowledge;
   logic              irq;

   modport master (
      output address, bus_enable, rw, write_data,
      input  read_data, acknowledge, irq
   );

   modport slave (
      input  address, bus_enable, rw, write_data,
      output read_data, acknowledge, irq
   );
endinterface

// File: rtl/dual_regbank_mbox.sv
// Two-master register bank between the HPS and NIOS buses: one mailbox per
// direction with full flags and doorbells, a host control word, a sampled
// status word and a pending/enable interrupt controller for each side.
module dual_regbank_mbox #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 3,
   parameter int NUM_IRQ  = 4,
   parameter int STATUS_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   dual_regbank_mbox_if.slave   hr,
   dual_regbank_mbox_if.slave   nr,
   input  logic [NUM_IRQ-1:0]   irq_src,
   input  logic [STATUS_W-1:0]  status_in,
   output logic [DATA_W-1:0]    ctrl_out
);
   localparam int PEND_W = NUM_IRQ + 1;

   localparam logic [ADDR_W-1:0] ADDR_H2N     = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_N2H     = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_STATUS  = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] ADDR_CONTROL = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] ADDR_PEND    = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ADDR_EN      = ADDR_W'(5);
   localparam logic [ADDR_W-1:0] ADDR_HSET    = ADDR_W'(6);

   logic                r_hAck;
   logic                r_nAck;
   logic [DATA_W-1:0]   r_hRdata;
   logic [DATA_W-1:0]   r_nRdata;
   logic [DATA_W-1:0]   r_h2nData;
   logic [DATA_W-1:0]   r_n2hData;
   logic                r_h2nFull;
   logic                r_n2hFull;
   logic [DATA_W-1:0]   r_ctrl;
   logic [STATUS_W-1:0] r_statusQ;
   logic [DATA_W-1:0]   r_hPend;
   logic [DATA_W-1:0]   r_hEn;
   logic [PEND_W-1:0]   r_nPend;
   logic [PEND_W-1:0]   r_nEn;
   logic [NUM_IRQ-1:0]  r_srcPrev;

   logic                w_hAccept;
   logic                w_nAccept;
   logic                w_hRead;
   logic                w_hWrite;
   logic                w_nRead;
   logic                w_nWrite;
   logic                w_hWrH2n;
   logic                w_hRdN2h;
   logic                w_hWrCtrl;
   logic                w_hWrPend;
   logic                w_hWrEn;
   logic                w_nRdH2n;
   logic                w_nWrN2h;
   logic                w_nWrPend;
   logic                w_nWrEn;
   logic                w_nWrHset;
   logic [DATA_W-1:0]   w_statusWord;
   logic [DATA_W-1:0]   w_hRdMux;
   logic [DATA_W-1:0]   w_nRdMux;
   logic [PEND_W-1:0]   w_nPendSet;
   logic [PEND_W-1:0]   w_nPendClr;
   logic [DATA_W-1:0]   w_hPendSet;
   logic [DATA_W-1:0]   w_hPendClr;

   // A request is taken only while no acknowledge is showing, which spaces accesses two cycles apart.
   assign w_hAccept = hr.bus_enable && !r_hAck;
   assign w_nAccept = nr.bus_enable && !r_nAck;
   assign w_hRead   = w_hAccept &&  hr.rw;
   assign w_hWrite  = w_hAccept && !hr.rw;
   assign w_nRead   = w_nAccept &&  nr.rw;
   assign w_nWrite  = w_nAccept && !nr.rw;

   assign w_hWrH2n  = w_hWrite && (hr.address == ADDR_H2N);
   assign w_hRdN2h  = w_hRead  && (hr.address == ADDR_N2H);
   assign w_hWrCtrl = w_hWrite && (hr.address == ADDR_CONTROL);
   assign w_hWrPend = w_hWrite && (hr.address == ADDR_PEND);
   assign w_hWrEn   = w_hWrite && (hr.address == ADDR_EN);
   assign w_nRdH2n  = w_nRead  && (nr.address == ADDR_H2N);
   assign w_nWrN2h  = w_nWrite && (nr.address == ADDR_N2H);
   assign w_nWrPend = w_nWrite && (nr.address == ADDR_PEND);
   assign w_nWrEn   = w_nWrite && (nr.address == ADDR_EN);
   assign w_nWrHset = w_nWrite && (nr.address == ADDR_HSET);

   // Rising edges of the hardware sources land in NIOS pending bits 1..NUM_IRQ, the doorbell in bit 0.
   assign w_nPendSet = {(irq_src & ~r_srcPrev), w_hWrH2n};
   assign w_nPendClr = w_nWrPend ? nr.write_data[PEND_W-1:0] : '0;
   assign w_hPendSet = (w_nWrHset ? nr.write_data : '0) | (w_nWrN2h ? DATA_W'(1) : '0);
   assign w_hPendClr = w_hWrPend ? hr.write_data : '0;

   assign hr.read_data   = r_hRdata;
   assign hr.acknowledge = r_hAck;
   assign hr.irq         = |(r_hPend & r_hEn);
   assign nr.read_data   = r_nRdata;
   assign nr.acknowledge = r_nAck;
   assign nr.irq         = |(r_nPend & r_nEn);
   assign ctrl_out       = r_ctrl;

   // Status word seen by both sides: sampled status above the two mailbox full flags.
   always_comb begin
      w_statusWord                 = '0;
      w_statusWord[STATUS_W+1:2]   = r_statusQ;
      w_statusWord[1]              = r_n2hFull;
      w_statusWord[0]              = r_h2nFull;
   end

   // HPS read decode; unmapped and write-only slots return zero.
   always_comb begin
      w_hRdMux = '0;
      case (hr.address)
         ADDR_H2N:     w_hRdMux = r_h2nData;
         ADDR_N2H:     w_hRdMux = r_n2hData;
         ADDR_STATUS:  w_hRdMux = w_statusWord;
         ADDR_CONTROL: w_hRdMux = r_ctrl;
         ADDR_PEND:    w_hRdMux = r_hPend;
         ADDR_EN:      w_hRdMux = r_hEn;
         default:      w_hRdMux = '0;
      endcase
   end

   // NIOS read decode; the HPS interrupt-set slot always reads zero.
   always_comb begin
      w_nRdMux = '0;
      case (nr.address)
         ADDR_H2N:     w_nRdMux = r_h2nData;
         ADDR_N2H:     w_nRdMux = r_n2hData;
         ADDR_STATUS:  w_nRdMux = w_statusWord;
         ADDR_CONTROL: w_nRdMux = r_ctrl;
         ADDR_PEND:    w_nRdMux[PEND_W-1:0] = r_nPend;
         ADDR_EN:      w_nRdMux[PEND_W-1:0] = r_nEn;
         default:      w_nRdMux = '0;
      endcase
   end

   // HPS handshake: acknowledge pulses the cycle after accept, read data is captured with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hAck   <= 1'b0;
         r_hRdata <= '0;
      end else begin
         r_hAck <= w_hAccept;
         if (w_hRead) begin
            r_hRdata <= w_hRdMux;
         end
      end
   end

   // NIOS handshake, independent of the HPS side.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_nAck   <= 1'b0;
         r_nRdata <= '0;
      end else begin
         r_nAck <= w_nAccept;
         if (w_nRead) begin
            r_nRdata <= w_nRdMux;
         end
      end
   end

   // Mailboxes: a write always overwrites and sets full; a write in the same cycle as the draining read keeps full set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_h2nData <= '0;
         r_n2hData <= '0;
         r_h2nFull <= 1'b0;
         r_n2hFull <= 1'b0;
      end else begin
         if (w_hWrH2n) begin
            r_h2nData <= hr.write_data;
         end
         if (w_nWrN2h) begin
            r_n2hData <= nr.write_data;
         end
         if (w_hWrH2n) begin
            r_h2nFull <= 1'b1;
         end else if (w_nRdH2n) begin
            r_h2nFull <= 1'b0;
         end
         if (w_nWrN2h) begin
            r_n2hFull <= 1'b1;
         end else if (w_hRdN2h) begin
            r_n2hFull <= 1'b0;
         end
      end
   end

   // Interrupt controllers: clear first, then OR in sets so a same-cycle set survives its own clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hPend <= '0;
         r_hEn   <= '0;
         r_nPend <= '0;
         r_nEn   <= '0;
      end else begin
         r_hPend <= (r_hPend & ~w_hPendClr) | w_hPendSet;
         r_nPend <= (r_nPend & ~w_nPendClr) | w_nPendSet;
         if (w_hWrEn) begin
            r_hEn <= hr.write_data;
         end
         if (w_nWrEn) begin
            r_nEn <= nr.write_data[PEND_W-1:0];
         end
      end
   end

   // Host control word plus per-cycle sampling of status and IRQ source history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ctrl    <= '0;
         r_statusQ <= '0;
         r_srcPrev <= '0;
      end else begin
         if (w_hWrCtrl) begin
            r_ctrl <= hr.write_data;
         end
         r_statusQ <= status_in;
         r_srcPrev <= irq_src;
      end
   end
endmodule

// File: doc/dual_regbank_mbox.md
Name: dual_regbank_mbox

Overview:
Parametrised two-master register bank between the HPS bus and the NIOS bus, both on the 50 MHz main clock. Provides a mailbox in each direction with full flags and doorbells, a host control word, a sampled status word, and a per-side interrupt controller with pending/enable registers. Hardware interrupt sources are edge-detected into the NIOS pending register. Successor to the fixed two-register cross-connect used with the camera path.

Parameters:
DATA_W, 32, register/bus data width
ADDR_W, 3, word address width per bus (8 slots)
NUM_IRQ, 4, hardware IRQ sources into NIOS (NUM_IRQ+1 <= DATA_W)
STATUS_W, 16, width of status_in (STATUS_W+2 <= DATA_W)

Ports:
clk  in  1  main clock
rst  in  1  asynchronous reset, active-high
hr_address  in  ADDR_W  HPS word address
hr_bus_enable  in  1  HPS request
hr_rw  in  1  1=read, 0=write
hr_write_data  in  DATA_W  HPS write data
hr_read_data  out  DATA_W  HPS read data
hr_acknowledge  out  1  HPS ack pulse
hr_irq  out  1  interrupt to HPS
nr_address  in  ADDR_W  NIOS word address
nr_bus_enable  in  1  NIOS request
nr_rw  in  1  1=read, 0=write
nr_write_data  in  DATA_W  NIOS write data
nr_read_data  out  DATA_W  NIOS read data
nr_acknowledge  out  1  NIOS ack pulse
nr_irq  out  1  interrupt to NIOS
irq_src  in  NUM_IRQ  hardware interrupt sources (level, same clock)
status_in  in  STATUS_W  hardware status, registered each cycle
ctrl_out  out  DATA_W  host control word

Behaviour:
- Reset: all registers, read_data, acknowledge, irq, ctrl_out, full flags, irq_src history = 0.
- Bus handshake, per side independently: accept when bus_enable && !acknowledge; acknowledge = 1 exactly one cycle after the accept edge, then 0. Back-to-back accesses are therefore at most every 2 cycles. read_data updates with ack and holds otherwise. Unmapped address: read returns 0; write ignored; still acked.
- HPS map:
  - 0 H2N_MBOX: RW. Write sets h2n_full and NIOS pending bit 0.
  - 1 N2H_MBOX: RO. Read clears n2h_full.
  - 2 STATUS: RO = {0, status_q, n2h_full, h2n_full}.
  - 3 CONTROL: RW, drives ctrl_out.
  - 4 HIRQ_PEND: read; write-1-to-clear.
  - 5 HIRQ_EN: RW.
- NIOS map:
  - 0 H2N_MBOX: RO. Read clears h2n_full.
  - 1 N2H_MBOX: RW. Write sets n2h_full and HPS pending bit 0.
  - 2 STATUS: same as HPS STATUS.
  - 3 CONTROL: RO echo.
  - 4 NIRQ_PEND: W1C.
  - 5 NIRQ_EN: RW.
  - 6 HIRQ_SET: write-1 sets HPS pending bits; reads 0.
- Pending widths: NIOS NUM_IRQ+1 bits. Bit 0 is the doorbell; bit i+1 is set on a rising edge of irq_src[i] (src & ~src_prev). src_prev resets to 0, so a source high at reset release raises its bit once. HPS pending is DATA_W bits.
- Priority: in any one cycle, set beats W1C clear on the same pending bit, and a mailbox write beats a read-clear of the same full flag (flag stays 1, reader gets old data).
- Writing a mailbox while full overwrites the data; the flag stays 1.
- irq = |(pend & en), computed from flops only, so it is visible in the cycle after the accept edge of the enabling or pending write.
- Enable writes do not alter pending bits.
- The status_q read is the value sampled on the previous edge.
- Reset mid-access: the ack is dropped and state cleared asynchronously; the access is lost.

Test Plan:
- Reset, read every HPS and NIOS address -> all 0, unmapped 0x7 reads 0, each access acked one cycle after accept.
- HPS writes H2N=0xDEADBEEF, NIOS EN=0x1 -> nr_irq=1, HPS STATUS bit0=1. NIOS reads addr 0 -> 0xDEADBEEF, STATUS bit0=0. NIOS writes PEND=0x1 -> nr_irq=0.
- NIOS EN=0x1E, pulse irq_src[2] high for 5 cycles -> NIOS PEND=0x08 (single set), nr_irq=1. Hold irq_src[0] high continuously -> bit1 set once, re-set only after low then high.
- Same cycle: irq_src[1] rising edge and NIOS W1C of 0x04 -> PEND bit2 remains 1.
- Same cycle: HPS writes H2N=0x5 and NIOS reads H2N -> NIOS gets old value, h2n_full stays 1.
- HPS EN=0x3, NIOS writes HIRQ_SET=0x2 then N2H=0x77 -> HPS PEND=0x3, hr_irq=1. HPS reads N2H -> 0x77, n2h_full=0. HPS W1C 0x3 -> hr_irq=0. HPS CONTROL=0xA5 -> ctrl_out=0xA5, NIOS addr 3 reads 0xA5.
